// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle controller.
package ctrl_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERROR} state_t;
    typedef enum logic [1:0] {CLS_R, CLS_I, CLS_LW, CLS_SW} cls_t;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [1:0] SEL_RES   = 2'b00;
    localparam logic [1:0] SEL_IMM   = 2'b01;
    localparam logic [1:0] SEL_IMM_S = 2'b10;
    localparam logic [1:0] SEL_NONE  = 2'b11;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts consecutive stalled handshake cycles; expired flags the cycle the count reaches TIMEOUT_CYC.
module wait_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end
    assign expired = en && (cnt == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with handshake timeouts and a retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       sel_b,
    output logic [3:0]       alu_op,
    output logic             reg_we,
    output logic             error,
    output logic [CNT_W-1:0] retired
);
    state_t     state, nxt;
    cls_t       cls, cls_d;
    logic [1:0] sel_d;
    logic [3:0] alu_d;
    logic       live, wait_en, expired, retire;

    wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait (
        .clk(clk), .rst_n(rst_n), .clr(nxt != state), .en(wait_en), .expired(expired)
    );

    always_comb begin
        nxt     = state;
        cls_d   = cls;
        sel_d   = sel_b;
        alu_d   = alu_op;
        wait_en = 1'b0;
        retire  = 1'b0;
        case (state)
            FETCH: begin
                wait_en = live && !imem_ready;
                if (live && imem_ready)
                    nxt = DECODE;
                else if (expired)
                    nxt = ERROR;
            end
            DECODE: begin
                nxt = EXEC;
                case (opcode)
                    OP_R:  begin cls_d = CLS_R;  sel_d = SEL_RES;   alu_d = {funct7_5, funct3}; end
                    OP_I:  begin cls_d = CLS_I;  sel_d = SEL_IMM;   alu_d = {1'b0, funct3}; end
                    OP_LW: begin cls_d = CLS_LW; sel_d = SEL_IMM;   alu_d = ALU_ADD; end
                    OP_SW: begin cls_d = CLS_SW; sel_d = SEL_IMM_S; alu_d = ALU_ADD; end
                    default: nxt = ERROR;
                endcase
            end
            EXEC: nxt = (cls == CLS_LW || cls == CLS_SW) ? MEM : WB;
            MEM: begin
                wait_en = !dmem_ready;
                if (dmem_ready) begin
                    nxt    = (cls == CLS_SW) ? FETCH : WB;
                    retire = (cls == CLS_SW);
                end else if (expired) begin
                    nxt = ERROR;
                end
            end
            WB: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
            default: nxt = ERROR;
        endcase
        // operand selects only carry meaning between DECODE exit and the next FETCH
        if (nxt == FETCH || nxt == ERROR) begin
            sel_d = SEL_NONE;
            alu_d = ALU_ADD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            live    <= 1'b0;
            cls     <= CLS_R;
            sel_b   <= SEL_NONE;
            alu_op  <= ALU_ADD;
            retired <= '0;
        end else begin
            state  <= nxt;
            live   <= 1'b1;
            cls    <= cls_d;
            sel_b  <= sel_d;
            alu_op <= alu_d;
            if (retire)
                retired <= retired + 1'b1;
        end
    end

    assign imem_req = (state == FETCH) && live;
    assign ir_we    = imem_req && imem_ready;
    assign pc_we    = ir_we;
    assign dmem_req = (state == MEM);
    assign dmem_we  = dmem_req && (cls == CLS_SW);
    assign reg_we   = (state == WB);
    assign error    = (state == ERROR);
endmodule
